// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one external memory port between the instruction-fetch
//            cache (IF) and the data cache (LS). Arbitrates line-fill reads
//            and store write-throughs, tags reads with a transaction ID and
//            routes returned lines back to the owning requester.
// Options  : MEM_ARB_FIXED_PRIO_EN - when defined, LS always wins a tie and
//            the round-robin pointer is not built.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int PA_WIDTH        = 32,
    parameter int REG_WIDTH       = 32,
    parameter int LINE_WIDTH      = 128,
    parameter int ID_WIDTH        = 3,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_if_req,
    input  logic [PA_WIDTH-1:0]   i_if_addr,
    output logic                  o_if_grant,
    output logic                  o_if_resp_valid,
    input  logic                  i_ls_req,
    input  logic                  i_ls_write,
    input  logic [PA_WIDTH-1:0]   i_ls_addr,
    input  logic [REG_WIDTH-1:0]  i_ls_data,
    output logic                  o_ls_grant,
    output logic                  o_ls_resp_valid,
    output logic [LINE_WIDTH-1:0] o_resp_data,
    output logic                  o_mem_enable,
    output logic                  o_mem_write,
    output logic [PA_WIDTH-1:0]   o_mem_addr,
    output logic [REG_WIDTH-1:0]  o_mem_data,
    output logic [ID_WIDTH-1:0]   o_mem_id,
    input  logic                  i_mem_ready,
    input  logic                  i_mem_enable,
    input  logic [LINE_WIDTH-1:0] i_mem_data,
    input  logic [ID_WIDTH-1:0]   i_mem_id_response,
    output logic                  o_mem_ack,
    output logic                  o_err_unknown_id
);

    localparam int                  c_DEPTH   = 1 << ID_WIDTH;
    localparam int                  c_CNT_W   = ID_WIDTH + 1;
    localparam logic [c_CNT_W-1:0]  c_MAX     = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE = c_CNT_W'(1);
    localparam logic [ID_WIDTH-1:0] c_ID_ONE  = ID_WIDTH'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                r_state;
    logic [c_DEPTH-1:0]    r_valid;
    logic [c_DEPTH-1:0]    r_owner;       // 1 = LS owns the ID, 0 = IF
    logic [ID_WIDTH-1:0]   r_id_ctr;
    logic [c_CNT_W-1:0]    r_outstanding;

    logic                  r_mem_enable;
    logic                  r_mem_write;
    logic [PA_WIDTH-1:0]   r_mem_addr;
    logic [REG_WIDTH-1:0]  r_mem_data;
    logic [ID_WIDTH-1:0]   r_mem_id;
    logic                  r_if_resp_valid;
    logic                  r_ls_resp_valid;
    logic [LINE_WIDTH-1:0] r_resp_data;
    logic                  r_err_unknown_id;

    logic                  w_can_issue;
    logic                  w_read_ok;
    logic                  w_if_elig;
    logic                  w_ls_elig;
    logic                  w_grant_if;
    logic                  w_grant_ls;
    logic                  w_any_grant;
    logic                  w_alloc;
    logic                  w_ack;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic                  r_rr_ls;       // 1 = LS wins the next tie
`endif

    // Eligibility, arbitration and response hit detection. Grants are gated
    // by reset so nothing is accepted while the block is held in reset.
    always_comb begin
        w_can_issue = (r_state == S_IDLE) || i_mem_ready;
        // Allocation looks only at registered valid bits, so a slot freed this
        // cycle becomes usable next cycle.
        w_read_ok   = (r_outstanding < c_MAX) && !r_valid[r_id_ctr];
        w_if_elig   = rst && w_can_issue && i_if_req && w_read_ok;
        w_ls_elig   = rst && w_can_issue && i_ls_req && (i_ls_write || w_read_ok);
`ifdef MEM_ARB_FIXED_PRIO_EN
        w_grant_ls  = w_ls_elig;
`else
        w_grant_ls  = w_ls_elig && (r_rr_ls || !w_if_elig);
`endif
        w_grant_if  = w_if_elig && !w_grant_ls;
        w_any_grant = w_grant_if || w_grant_ls;
        w_alloc     = w_grant_if || (w_grant_ls && !i_ls_write);
        w_ack       = i_mem_enable && r_valid[i_mem_id_response];
    end

    // Request FSM plus the registered memory request fields.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_mem_enable <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_data   <= '0;
            r_mem_id     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_grant) begin
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (i_mem_ready && !w_any_grant) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_any_grant) begin
                r_mem_enable <= 1'b1;
                r_mem_write  <= w_grant_ls && i_ls_write;
                r_mem_addr   <= w_grant_ls ? i_ls_addr : i_if_addr;
                r_mem_data   <= (w_grant_ls && i_ls_write) ? i_ls_data : '0;
                r_mem_id     <= w_alloc ? r_id_ctr : '0;
            end else if (r_state == S_SEND && i_mem_ready) begin
                r_mem_enable <= 1'b0;
            end
        end
    end

    // Transaction table: allocate on read grant, free on a hitting response.
    // A hit needs a valid entry and allocation needs an invalid one, so the
    // two never touch the same slot in one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid       <= '0;
            r_owner       <= '0;
            r_id_ctr      <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_ack) begin
                r_valid[i_mem_id_response] <= 1'b0;
            end
            if (w_alloc) begin
                r_valid[r_id_ctr] <= 1'b1;
                r_owner[r_id_ctr] <= w_grant_ls;
                r_id_ctr          <= r_id_ctr + c_ID_ONE;
            end
            case ({w_alloc, w_ack})
                2'b10:   r_outstanding <= r_outstanding + c_CNT_ONE;
                2'b01:   r_outstanding <= r_outstanding - c_CNT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Response routing to the owner and the sticky unknown-ID flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_if_resp_valid  <= 1'b0;
            r_ls_resp_valid  <= 1'b0;
            r_resp_data      <= '0;
            r_err_unknown_id <= 1'b0;
        end else begin
            r_if_resp_valid <= w_ack && !r_owner[i_mem_id_response];
            r_ls_resp_valid <= w_ack &&  r_owner[i_mem_id_response];
            if (w_ack) begin
                r_resp_data <= i_mem_data;
            end
            if (i_mem_enable && !r_valid[i_mem_id_response]) begin
                r_err_unknown_id <= 1'b1;
            end
        end
    end

`ifndef MEM_ARB_FIXED_PRIO_EN
    // Round-robin pointer moves to the side that was not just granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ls <= 1'b1;
        end else if (w_grant_ls) begin
            r_rr_ls <= 1'b0;
        end else if (w_grant_if) begin
            r_rr_ls <= 1'b1;
        end
    end
`endif

    assign o_if_grant       = w_grant_if;
    assign o_ls_grant       = w_grant_ls;
    assign o_mem_ack        = w_ack;
    assign o_mem_enable     = r_mem_enable;
    assign o_mem_write      = r_mem_write;
    assign o_mem_addr       = r_mem_addr;
    assign o_mem_data       = r_mem_data;
    assign o_mem_id         = r_mem_id;
    assign o_if_resp_valid  = r_if_resp_valid;
    assign o_ls_resp_valid  = r_ls_resp_valid;
    assign o_resp_data      = r_resp_data;
    assign o_err_unknown_id = r_err_unknown_id;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter. Inputs change on
//            the falling edge; combinational outputs are sampled 1 ns later
//            and registered outputs at the following falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic         clk;
    logic         rst;
    logic         i_if_req;
    logic [31:0]  i_if_addr;
    logic         o_if_grant;
    logic         o_if_resp_valid;
    logic         i_ls_req;
    logic         i_ls_write;
    logic [31:0]  i_ls_addr;
    logic [31:0]  i_ls_data;
    logic         o_ls_grant;
    logic         o_ls_resp_valid;
    logic [127:0] o_resp_data;
    logic         o_mem_enable;
    logic         o_mem_write;
    logic [31:0]  o_mem_addr;
    logic [31:0]  o_mem_data;
    logic [2:0]   o_mem_id;
    logic         i_mem_ready;
    logic         i_mem_enable;
    logic [127:0] i_mem_data;
    logic [2:0]   i_mem_id_response;
    logic         o_mem_ack;
    logic         o_err_unknown_id;

    int n_checks;
    int n_fail;

    mem_arbiter #(
        .PA_WIDTH        (32),
        .REG_WIDTH       (32),
        .LINE_WIDTH      (128),
        .ID_WIDTH        (3),
        .MAX_OUTSTANDING (4)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .i_if_req          (i_if_req),
        .i_if_addr         (i_if_addr),
        .o_if_grant        (o_if_grant),
        .o_if_resp_valid   (o_if_resp_valid),
        .i_ls_req          (i_ls_req),
        .i_ls_write        (i_ls_write),
        .i_ls_addr         (i_ls_addr),
        .i_ls_data         (i_ls_data),
        .o_ls_grant        (o_ls_grant),
        .o_ls_resp_valid   (o_ls_resp_valid),
        .o_resp_data       (o_resp_data),
        .o_mem_enable      (o_mem_enable),
        .o_mem_write       (o_mem_write),
        .o_mem_addr        (o_mem_addr),
        .o_mem_data        (o_mem_data),
        .o_mem_id          (o_mem_id),
        .i_mem_ready       (i_mem_ready),
        .i_mem_enable      (i_mem_enable),
        .i_mem_data        (i_mem_data),
        .i_mem_id_response (i_mem_id_response),
        .o_mem_ack         (o_mem_ack),
        .o_err_unknown_id  (o_err_unknown_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        i_if_req          = 1'b0;
        i_if_addr         = '0;
        i_ls_req          = 1'b0;
        i_ls_write        = 1'b0;
        i_ls_addr         = '0;
        i_ls_data         = '0;
        i_mem_ready       = 1'b1;
        i_mem_enable      = 1'b0;
        i_mem_data        = '0;
        i_mem_id_response = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        i_if_req     = 1'b1;
        i_ls_req     = 1'b1;
        i_mem_enable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if ({o_if_grant, o_ls_grant, o_mem_ack} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_comb: got grant_if/grant_ls/ack=%b want 000", {o_if_grant, o_ls_grant, o_mem_ack});
        end
        n_checks++;
        if ({o_mem_enable, o_mem_write, o_mem_addr, o_mem_data, o_mem_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: got en=%b wr=%b addr=%h data=%h id=%0d want all 0", o_mem_enable, o_mem_write, o_mem_addr, o_mem_data, o_mem_id);
        end
        n_checks++;
        if ({o_if_resp_valid, o_ls_resp_valid, o_err_unknown_id, o_resp_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_resp: got ifv=%b lsv=%b err=%b data=%h want all 0", o_if_resp_valid, o_ls_resp_valid, o_err_unknown_id, o_resp_data);
        end
        clear_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_single_read();
        do_reset();
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_1000;
        #1;
        n_checks++;
        if (o_if_grant !== 1'b1 || o_ls_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL single_grant: got if=%b ls=%b want if=1 ls=0", o_if_grant, o_ls_grant);
        end
        @(negedge clk);
        i_if_req = 1'b0;
        n_checks++;
        if ({o_mem_enable, o_mem_write, o_mem_id, o_mem_addr} !== {1'b1, 1'b0, 3'd0, 32'h0000_1000}) begin
            n_fail++;
            $display("FAIL single_req: got en=%b wr=%b id=%0d addr=%h want en=1 wr=0 id=0 addr=00001000", o_mem_enable, o_mem_write, o_mem_id, o_mem_addr);
        end
        @(negedge clk);
        n_checks++;
        if (o_mem_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got en=%b want 0", o_mem_enable);
        end
        @(negedge clk);
        i_mem_enable      = 1'b1;
        i_mem_id_response = 3'd0;
        i_mem_data        = {16{8'hA5}};
        #1;
        n_checks++;
        if (o_mem_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ack: got %b want 1", o_mem_ack);
        end
        @(negedge clk);
        i_mem_enable = 1'b0;
        n_checks++;
        if ({o_if_resp_valid, o_ls_resp_valid} !== 2'b10 || o_resp_data !== {16{8'hA5}}) begin
            n_fail++;
            $display("FAIL single_resp: got ifv=%b lsv=%b data=%h want ifv=1 lsv=0 data=a5..a5", o_if_resp_valid, o_ls_resp_valid, o_resp_data);
        end
        @(negedge clk);
        n_checks++;
        if (o_if_resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_pulse: got ifv=%b want 0", o_if_resp_valid);
        end
    endtask

    // Leaves four reads outstanding and both requesters asserting reads.
    task automatic test_round_robin();
        logic exp_ls;
        do_reset();
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_2000;
        i_ls_req  = 1'b1;
        i_ls_addr = 32'h0000_3000;
        for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_ls = 1'b1;
`else
            exp_ls = (i % 2 == 0);
`endif
            #1;
            n_checks++;
            if (o_ls_grant !== exp_ls || o_if_grant !== !exp_ls) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got ls=%b if=%b want ls=%b if=%b", i, o_ls_grant, o_if_grant, exp_ls, !exp_ls);
            end
            @(negedge clk);
            n_checks++;
            if (o_mem_enable !== 1'b1 || o_mem_id !== 3'(i) || o_mem_addr !== (exp_ls ? 32'h0000_3000 : 32'h0000_2000)) begin
                n_fail++;
                $display("FAIL rr_req%0d: got en=%b id=%0d addr=%h want en=1 id=%0d", i, o_mem_enable, o_mem_id, o_mem_addr, i);
            end
        end
        #1;
        n_checks++;
        if ({o_if_grant, o_ls_grant} !== 2'b00) begin
            n_fail++;
            $display("FAIL rr_full: got if=%b ls=%b want 00 with 4 outstanding", o_if_grant, o_ls_grant);
        end
    endtask

    // Continues from test_round_robin with the table full.
    task automatic test_blocked_read();
        @(negedge clk);
        i_ls_write = 1'b1;
        i_ls_addr  = 32'h0000_4000;
        i_ls_data  = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if ({o_ls_grant, o_if_grant} !== 2'b10) begin
            n_fail++;
            $display("FAIL blk_write_grant: got ls=%b if=%b want ls=1 if=0", o_ls_grant, o_if_grant);
        end
        @(negedge clk);
        i_ls_req   = 1'b0;
        i_ls_write = 1'b0;
        n_checks++;
        if ({o_mem_write, o_mem_id, o_mem_addr, o_mem_data} !== {1'b1, 3'd0, 32'h0000_4000, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL blk_write_req: got wr=%b id=%0d addr=%h data=%h want wr=1 id=0 addr=00004000 data=deadbeef", o_mem_write, o_mem_id, o_mem_addr, o_mem_data);
        end
        i_mem_enable      = 1'b1;
        i_mem_id_response = 3'd1;
        i_mem_data        = {16{8'h11}};
        #1;
        n_checks++;
        if (o_mem_ack !== 1'b1 || o_if_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL blk_free: got ack=%b if=%b want ack=1 if=0", o_mem_ack, o_if_grant);
        end
        @(negedge clk);
        i_mem_enable = 1'b0;
        n_checks++;
`ifdef MEM_ARB_FIXED_PRIO_EN
        if ({o_if_resp_valid, o_ls_resp_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL blk_resp: got ifv=%b lsv=%b want 01", o_if_resp_valid, o_ls_resp_valid);
        end
`else
        if ({o_if_resp_valid, o_ls_resp_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL blk_resp: got ifv=%b lsv=%b want 10", o_if_resp_valid, o_ls_resp_valid);
        end
`endif
        #1;
        n_checks++;
        if (o_if_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL blk_regrant: got if=%b want 1", o_if_grant);
        end
        @(negedge clk);
        i_if_req = 1'b0;
        n_checks++;
        if ({o_mem_write, o_mem_id, o_mem_addr} !== {1'b0, 3'd4, 32'h0000_2000}) begin
            n_fail++;
            $display("FAIL blk_regrant_req: got wr=%b id=%0d addr=%h want wr=0 id=4 addr=00002000", o_mem_write, o_mem_id, o_mem_addr);
        end
    endtask

    task automatic test_ready_stall();
        do_reset();
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_5000;
        #1;
        n_checks++;
        if (o_if_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_grant: got %b want 1", o_if_grant);
        end
        @(negedge clk);
        i_if_req    = 1'b0;
        i_mem_ready = 1'b0;
        i_ls_req    = 1'b1;
        i_ls_write  = 1'b1;
        i_ls_addr   = 32'h0000_6000;
        i_ls_data   = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++;
            if (o_ls_grant !== 1'b0 || o_mem_enable !== 1'b1 || o_mem_addr !== 32'h0000_5000 || o_mem_data !== 32'h0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got ls=%b en=%b addr=%h data=%h want ls=0 en=1 addr=00005000 data=0", i, o_ls_grant, o_mem_enable, o_mem_addr, o_mem_data);
            end
            @(negedge clk);
        end
        i_mem_ready = 1'b1;
        #1;
        n_checks++;
        if (o_ls_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_b2b_grant: got %b want 1", o_ls_grant);
        end
        @(negedge clk);
        i_ls_req   = 1'b0;
        i_ls_write = 1'b0;
        n_checks++;
        if ({o_mem_enable, o_mem_write, o_mem_addr, o_mem_data} !== {1'b1, 1'b1, 32'h0000_6000, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL stall_b2b_req: got en=%b wr=%b addr=%h data=%h want en=1 wr=1 addr=00006000 data=12345678", o_mem_enable, o_mem_write, o_mem_addr, o_mem_data);
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_0100;
        #1;
        n_checks++;
        if (o_if_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL ooo_grant0: got %b want 1", o_if_grant);
        end
        @(negedge clk);
        i_if_addr = 32'h0000_0140;
        #1;
        n_checks++;
        if (o_if_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL ooo_grant1: got %b want 1", o_if_grant);
        end
        @(negedge clk);
        i_if_req  = 1'b0;
        i_ls_req  = 1'b1;
        i_ls_addr = 32'h0000_0180;
        #1;
        n_checks++;
        if (o_ls_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL ooo_grant2: got %b want 1", o_ls_grant);
        end
        @(negedge clk);
        i_ls_req = 1'b0;
        n_checks++;
        if (o_mem_id !== 3'd2) begin
            n_fail++;
            $display("FAIL ooo_id2: got %0d want 2", o_mem_id);
        end
        i_mem_enable      = 1'b1;
        i_mem_id_response = 3'd2;
        i_mem_data        = {16{8'h22}};
        #1;
        n_checks++;
        if (o_mem_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL ooo_ack2: got %b want 1", o_mem_ack);
        end
        @(negedge clk);
        i_mem_id_response = 3'd0;
        i_mem_data        = {16{8'h11}};
        n_checks++;
        if ({o_if_resp_valid, o_ls_resp_valid} !== 2'b01 || o_resp_data !== {16{8'h22}}) begin
            n_fail++;
            $display("FAIL ooo_resp2: got ifv=%b lsv=%b data=%h want ifv=0 lsv=1 data=22..22", o_if_resp_valid, o_ls_resp_valid, o_resp_data);
        end
        #1;
        n_checks++;
        if (o_mem_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL ooo_ack0: got %b want 1", o_mem_ack);
        end
        @(negedge clk);
        i_mem_id_response = 3'd5;
        i_mem_data        = {16{8'h55}};
        n_checks++;
        if ({o_if_resp_valid, o_ls_resp_valid} !== 2'b10 || o_resp_data !== {16{8'h11}}) begin
            n_fail++;
            $display("FAIL ooo_resp0: got ifv=%b lsv=%b data=%h want ifv=1 lsv=0 data=11..11", o_if_resp_valid, o_ls_resp_valid, o_resp_data);
        end
        #1;
        n_checks++;
        if (o_mem_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL ooo_ack5: got %b want 0", o_mem_ack);
        end
        @(negedge clk);
        i_mem_enable = 1'b0;
        n_checks++;
        if ({o_err_unknown_id, o_if_resp_valid, o_ls_resp_valid} !== 3'b100 || o_resp_data !== {16{8'h11}}) begin
            n_fail++;
            $display("FAIL ooo_unknown: got err=%b ifv=%b lsv=%b data=%h want err=1 ifv=0 lsv=0 data=11..11", o_err_unknown_id, o_if_resp_valid, o_ls_resp_valid, o_resp_data);
        end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (o_err_unknown_id !== 1'b1) begin
            n_fail++;
            $display("FAIL ooo_sticky: got err=%b want 1", o_err_unknown_id);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        n_checks++;
        if (o_err_unknown_id !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_err_clear: got err=%b want 0", o_err_unknown_id);
        end
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_0700;
        @(negedge clk);
        i_if_req  = 1'b0;
        i_ls_req  = 1'b1;
        i_ls_addr = 32'h0000_0780;
        @(negedge clk);
        i_ls_req    = 1'b0;
        i_mem_ready = 1'b0;
        n_checks++;
        if ({o_mem_enable, o_mem_id, o_mem_addr} !== {1'b1, 3'd1, 32'h0000_0780}) begin
            n_fail++;
            $display("FAIL mid_send: got en=%b id=%0d addr=%h want en=1 id=1 addr=00000780", o_mem_enable, o_mem_id, o_mem_addr);
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({o_mem_enable, o_mem_write, o_mem_id, o_mem_addr, o_mem_data, o_if_grant, o_ls_grant, o_mem_ack} !== '0) begin
            n_fail++;
            $display("FAIL mid_async: got en=%b wr=%b id=%0d addr=%h data=%h want all 0", o_mem_enable, o_mem_write, o_mem_id, o_mem_addr, o_mem_data);
        end
        @(negedge clk);
        rst         = 1'b1;
        i_mem_ready = 1'b1;
        @(negedge clk);
        i_mem_enable      = 1'b1;
        i_mem_id_response = 3'd1;
        i_mem_data        = {16{8'h77}};
        #1;
        n_checks++;
        if (o_mem_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_stale_ack: got %b want 0", o_mem_ack);
        end
        @(negedge clk);
        i_mem_enable = 1'b0;
        n_checks++;
        if ({o_err_unknown_id, o_if_resp_valid, o_ls_resp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL mid_stale_err: got err=%b ifv=%b lsv=%b want 100", o_err_unknown_id, o_if_resp_valid, o_ls_resp_valid);
        end
        i_if_req  = 1'b1;
        i_if_addr = 32'h0000_0800;
        #1;
        n_checks++;
        if (o_if_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_regrant: got %b want 1", o_if_grant);
        end
        @(negedge clk);
        i_if_req = 1'b0;
        n_checks++;
        if (o_mem_id !== 3'd0 || o_mem_addr !== 32'h0000_0800) begin
            n_fail++;
            $display("FAIL mid_id_ctr: got id=%0d addr=%h want id=0 addr=00000800", o_mem_id, o_mem_addr);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_blocked_read();
        test_ready_stall();
        test_out_of_order();
        test_reset_mid();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
